cpu_boot_loader: RTL

//  Upstream of the cpu top. Streams a program image from a host (valid/ready, 32-bit beats) into

---
 rtl/cpu_boot_loader_if.sv | 59 +++++
 rtl/cpu_boot_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_boot_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_boot_loader_if
//  Description : Bundle of the host beat stream and both external memory
//                write ports used by cpu_boot_loader.
//                  s_valid/s_ready/s_data            host stream, 32-bit beats
//                  addr_ext/wen_ext/ren_ext/wdata_ext instruction memory port
//                  addr_ext_2/wen_ext_2/ren_ext_2/
//                  wdata_ext_2                        data memory port
//                Modport 'slave' is the loader's view (consumes beats, drives
//                the memory ports); 'master' is the host/observer view.
//  Revision    : 1.0  initial release
// ============================================================================
interface cpu_boot_loader_if;

  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;

  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;

  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  addr_ext,
    input  wen_ext,
    input  ren_ext,
    input  wdata_ext,
    input  addr_ext_2,
    input  wen_ext_2,
    input  ren_ext_2,
    input  wdata_ext_2
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output addr_ext,
    output wen_ext,
    output ren_ext,
    output wdata_ext,
    output addr_ext_2,
    output wen_ext_2,
    output ren_ext_2,
    output wdata_ext_2
  );

endinterface : cpu_boot_loader_if
`default_nettype wire

// File: rtl/cpu_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_boot_loader
//  Description : Streams a program image from a host into instruction and
//                data memory, then enables the cpu for a bounded number of
//                cycles and reports done/err.
//                Image: N_I, N_I instruction words, N_D, 2*N_D data words
//                (each 64-bit data word sent low half first).
//  Ports       :
//    clk          in   clock
//    arst_n       in   synchronous active-low reset
//    start        in   load request pulse (honoured in IDLE or DONE only)
//    run_limit    in   cpu enable duration, latched on accepted start
//    bus          if   host stream + imem/dmem write ports (slave view)
//    cpu_enable   out  high for run_limit cycles after the load
//    busy         out  load/run in progress
//    done         out  load (and run) complete
//    err          out  header exceeded memory capacity; cleared by reset only
//    cycle_count  out  cycles spent with cpu_enable high
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_boot_loader #(
  parameter int unsigned IMEM_WORDS = 512,
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  wire logic        clk,
  input  wire logic        arst_n,
  input  wire logic        start,
  input  wire logic [31:0] run_limit,
  cpu_boot_loader_if.slave bus,
  output logic             cpu_enable,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      cycle_count
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_HDR_I = 4'd1,
    S_LD_I  = 4'd2,
    S_HDR_D = 4'd3,
    S_LD_D  = 4'd4,
    S_FLUSH = 4'd5,
    S_RUN   = 4'd6,
    S_DONE  = 4'd7,
    S_ERR   = 4'd8
  } state_t;

  state_t state_q, state_d;

  // Beats expected in the current load section and beats taken so far.
  // For the data section the target is 2*N_D (two beats per 64-bit word).
  logic [31:0] n_q,      n_d;
  logic [31:0] idx_q,    idx_d;
  logic [31:0] lo_q,     lo_d;
  logic [31:0] limit_q,  limit_d;
  logic [31:0] cnt_q,    cnt_d;

  logic        wen_i_q,   wen_i_d;
  logic [63:0] addr_i_q,  addr_i_d;
  logic [31:0] wdata_i_q, wdata_i_d;
  logic        wen_d_q,   wen_d_d;
  logic [63:0] addr_d_q,  addr_d_d;
  logic [63:0] wdata_d_q, wdata_d_d;

  logic        w_beat;
  logic        w_last;

  assign w_beat = bus.s_valid & bus.s_ready;
  // Current beat closes the section (n_q is never 0 inside LD_I/LD_D).
  assign w_last = (idx_q == (n_q - 32'd1));

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    lo_d      = lo_q;
    limit_d   = limit_q;
    cnt_d     = cnt_q;
    // Strobes are single-cycle; addresses and data hold between strobes.
    wen_i_d   = 1'b0;
    addr_i_d  = addr_i_q;
    wdata_i_d = wdata_i_q;
    wen_d_d   = 1'b0;
    addr_d_d  = addr_d_q;
    wdata_d_d = wdata_d_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_HDR_I;
          cnt_d   = '0;
          limit_d = run_limit;
        end
      end

      S_HDR_I: begin
        if (w_beat) begin
          idx_d = '0;
          n_d   = bus.s_data;
          if (bus.s_data > IMEM_WORDS) begin
            state_d = S_ERR;
          end else if (bus.s_data == 32'd0) begin
            state_d = S_HDR_D;
          end else begin
            state_d = S_LD_I;
          end
        end
      end

      S_LD_I: begin
        if (w_beat) begin
          wen_i_d   = 1'b1;
          addr_i_d  = {30'd0, idx_q, 2'b00};
          wdata_i_d = bus.s_data;
          idx_d     = idx_q + 32'd1;
          if (w_last) begin
            state_d = S_HDR_D;
          end
        end
      end

      S_HDR_D: begin
        if (w_beat) begin
          idx_d = '0;
          n_d   = {bus.s_data[30:0], 1'b0};
          if (bus.s_data > DMEM_WORDS) begin
            state_d = S_ERR;
          end else if (bus.s_data == 32'd0) begin
            state_d = S_FLUSH;
          end else begin
            state_d = S_LD_D;
          end
        end
      end

      S_LD_D: begin
        if (w_beat) begin
          if (!idx_q[0]) begin
            lo_d = bus.s_data;
          end else begin
            // Odd beat completes word idx_q/2: byte address 8*(idx_q/2).
            wen_d_d   = 1'b1;
            addr_d_d  = {30'd0, idx_q[31:1], 3'b000};
            wdata_d_d = {bus.s_data, lo_q};
          end
          idx_d = idx_q + 32'd1;
          if (w_last) begin
            state_d = S_FLUSH;
          end
        end
      end

      S_FLUSH: begin
        // The final registered write strobe is on the bus during this cycle.
        state_d = (limit_q == 32'd0) ? S_DONE : S_RUN;
      end

      S_RUN: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == (limit_q - 32'd1)) begin
          state_d = S_DONE;
        end
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      idx_q     <= '0;
      lo_q      <= '0;
      limit_q   <= '0;
      cnt_q     <= '0;
      wen_i_q   <= 1'b0;
      addr_i_q  <= '0;
      wdata_i_q <= '0;
      wen_d_q   <= 1'b0;
      addr_d_q  <= '0;
      wdata_d_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      lo_q      <= lo_d;
      limit_q   <= limit_d;
      cnt_q     <= cnt_d;
      wen_i_q   <= wen_i_d;
      addr_i_q  <= addr_i_d;
      wdata_i_q <= wdata_i_d;
      wen_d_q   <= wen_d_d;
      addr_d_q  <= addr_d_d;
      wdata_d_q <= wdata_d_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.s_ready     = (state_q == S_HDR_I) || (state_q == S_LD_I) ||
                           (state_q == S_HDR_D) || (state_q == S_LD_D);
  assign bus.addr_ext    = addr_i_q;
  assign bus.wen_ext     = wen_i_q;
  assign bus.ren_ext     = 1'b0;
  assign bus.wdata_ext   = wdata_i_q;
  assign bus.addr_ext_2  = addr_d_q;
  assign bus.wen_ext_2   = wen_d_q;
  assign bus.ren_ext_2   = 1'b0;
  assign bus.wdata_ext_2 = wdata_d_q;

  assign cpu_enable  = (state_q == S_RUN);
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign done        = (state_q == S_DONE);
  assign err         = (state_q == S_ERR);
  assign cycle_count = cnt_q;

endmodule : cpu_boot_loader
`default_nettype wire
